// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields into a 32-bit instruction word.
// The immediate is range/alignment checked for its format; a failing request
// is stored as a NOP with its error flag set. Results queue in a small FIFO
// that has valid/ready on both sides and no combinational ready path.
module inst_encoder #(
    parameter int DEPTH = 2,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_fmt,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic [6:0]       i_funct7,
    input  logic [4:0]       i_rd,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    input  logic [31:0]      i_imm,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_out_inst,
    output logic             o_out_err,
    output logic [ERR_W-1:0] o_err_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // Each entry carries {err, inst}
    logic [32:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [ERR_W-1:0] r_err_cnt;

    logic [31:0] w_raw;
    logic        w_err;
    logic [31:0] w_inst;
    logic        w_push;
    logic        w_pop;
    logic        w_is_ok;
    logic        w_b_ok;
    logic        w_j_ok;

    // Sign-extension checks: the upper bits must all replicate the top immediate bit
    assign w_is_ok = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_b_ok  = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign w_j_ok  = (&i_imm[31:20]) | ~(|i_imm[31:20]);

    // Field packing and validation for the request presented this cycle
    always_comb begin
        w_raw = NOP;
        w_err = 1'b0;
        case (i_fmt)
            FMT_R: w_raw = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            FMT_I: begin
                w_raw = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                w_err = ~w_is_ok;
            end
            FMT_S: begin
                w_raw = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                w_err = ~w_is_ok;
            end
            FMT_B: begin
                w_raw = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                         i_imm[4:1], i_imm[11], i_opcode};
                w_err = ~w_b_ok | i_imm[0];
            end
            FMT_U: begin
                w_raw = {i_imm[31:12], i_rd, i_opcode};
                w_err = |i_imm[11:0];
            end
            FMT_J: begin
                w_raw = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                w_err = ~w_j_ok | i_imm[0];
            end
            default: w_err = 1'b1;
        endcase
    end

    assign w_inst = w_err ? NOP : w_raw;

    // Readiness depends only on registered occupancy, never on i_out_ready
    assign o_in_ready  = (r_count != CW'(DEPTH));
    assign o_out_valid = (r_count != '0);
    assign w_push      = i_in_valid & o_in_ready;
    assign w_pop       = o_out_valid & i_out_ready;

    assign o_out_inst = r_mem[r_rd_ptr][31:0];
    assign o_out_err  = r_mem[r_rd_ptr][32];
    assign o_err_cnt  = r_err_cnt;

    // FIFO storage, pointers and occupancy; reset discards everything buffered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_err, w_inst};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating count of accepted requests that failed validation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_push && w_err && (r_err_cnt != {ERR_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

endmodule
